tx_encode: RTL

- Transmit-side encoder that produces the 10-bit checksummed codeword consumed directly by the receive decoder.
- Accepts 7-bit payload words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Appends a 3-bit checksum and presents each codeword from a registered output stage with valid/ready.
- Includes a per-word error-injection flag so benches can force decoder "Error" reports.

---
 rtl/tx_encode.sv | 133 +++++++++++++
 1 files changed

// File: rtl/tx_encode.sv
// tx_encode: transmit-side encoder for the 10-bit checksummed codeword.
//
// Payload words (7 bits) arrive on a valid/ready handshake and are buffered
// in a DEPTH-entry FIFO together with a per-word error-injection flag. The
// FIFO head is encoded and loaded into a registered output stage:
//   out_word[9:7] = ~popcount(payload[5:0])  (bit 7 inverted if inj_err)
//   out_word[6:0] = payload
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   payload offered
//   in_ready   encoder can accept payload (low while in reset or FIFO full)
//   in_data    7-bit payload word
//   inj_err    captured with in_data; corrupts that word's checksum
//   out_valid  out_word holds a codeword
//   out_ready  downstream accepts out_word
//   out_word   {checksum[2:0], payload[6:0]}
//   fill       FIFO occupancy (output register not counted)
//   count      codewords delivered, wrapping at 16 bits
module tx_encode #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    in_data,
  input  logic          inj_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [9:0]    out_word,
  output logic [AW:0]   fill,
  output logic [15:0]   count
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Each entry is {inj_err, payload}.
  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   fill_reg;
  logic [AW:0]   fill_next;
  logic          out_valid_reg;
  logic [9:0]    out_word_reg;
  logic [15:0]   count_reg;

  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [2:0]    ones;
  logic [2:0]    chk;
  logic [9:0]    enc_word;

  assign full     = (fill_reg == FULL_LVL);
  // Gated by rst_n so nothing is advertised (or accepted) during reset.
  assign in_ready = rst_n && !full;
  assign push     = in_valid && in_ready;
  // Refill the output stage whenever it is empty or being drained this cycle.
  // Uses the registered fill, so a word pushed this cycle is never popped
  // in the same cycle (no pass-through) and unwritten entries are never read.
  assign pop      = (!out_valid_reg || out_ready) && (fill_reg != '0);

  assign head = mem[rd_ptr_reg];

  always_comb begin
    ones = '0;
    for (int i = 0; i < 6; i++) begin
      ones = ones + {2'b00, head[i]};
    end
  end

  assign chk = ~ones;
  // The injected error flips only bit 7 (checksum LSB), after encoding.
  assign enc_word = {chk[2], chk[1], chk[0] ^ head[7], head[6:0]};

  always_comb begin
    fill_next = fill_reg;
    case ({push, pop})
      2'b10:   fill_next = fill_reg + (AW+1)'(1);
      2'b01:   fill_next = fill_reg - (AW+1)'(1);
      default: fill_next = fill_reg;
    endcase
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {inj_err, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fill_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_word_reg  <= 10'h000;
      count_reg     <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      fill_reg <= fill_next;

      if (pop) begin
        out_valid_reg <= 1'b1;
        out_word_reg  <= enc_word;
      end else if (out_ready) begin
        // Drained with nothing to replace it; out_word keeps its last value.
        out_valid_reg <= 1'b0;
      end

      if (out_valid_reg && out_ready) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_word  = out_word_reg;
  assign fill      = fill_reg;
  assign count     = count_reg;

endmodule
